// File: rtl/response_pkg.sv
// Shared constants for the processor response path: word width, FIFO depth,
// source count, occupancy-counter width and the grant-index width.
// No ports; imported by the arbiter, the response FIFO and the sources.
package response_pkg;

  localparam int NUM_REQ    = 4;
  localparam int WORD_SIZE  = 45;
  localparam int FIFO_DEPTH = 21;
  localparam int CNT_W      = 5;
  localparam int GNT_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Index reached by stepping 'off' places past 'base' on a ring of n slots.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/response_fifo_arbiter_rr.sv
// Round-robin grant search: scans req_valid starting one past last_ptr,
// wrapping, and grants the first valid source when has_space is high.
// Latency: purely combinational. Backpressure: has_space low blocks all grants.
// Ports:
//   req_valid  in  NREQ   per-source request
//   last_ptr   in  IDX_W  index of the previously granted source
//   has_space  in  1      downstream room for one more word
//   grant      out NREQ   one-hot grant, or zero
//   grant_idx  out IDX_W  encoded index of the grant (0 when no grant)
module rr_arbiter
  import response_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [IDX_W-1:0] last_ptr,
  input  logic             has_space,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Offset NREQ lands back on last_ptr itself, so a lone requester that was
  // also the last winner still gets served every cycle.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'(rr_wrap(int'(last_ptr), k, NREQ));
      if (!found && has_space && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/response_fifo_arbiter.sv
// Shares the response FIFO among NUM_REQ sources: round-robin pick of one
// valid source per cycle, word registered once before the FIFO write port.
// Latency: accept in cycle N -> fifo_write_enable/fifo_data_in in cycle N+1.
// Backpressure: own occupancy counter (reserved at accept) gates req_ready
// when FIFO_DEPTH entries are held; no same-cycle pop bypass.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_data  per-source word offer (source i at [i*WORD_SIZE +: WORD_SIZE])
//   req_ready           one-hot grant for this cycle (zero in reset)
//   fifo_write_enable   registered write strobe
//   fifo_data_in        registered write word
//   fifo_read_enable    consumer pop, as seen by the FIFO
//   occupancy           accepted minus popped entries
//   grant_id            index of the last accepted source
//   underflow_err       sticky: pop seen with occupancy 0
module response_fifo_arbiter #(
  parameter int NUM_REQ    = response_pkg::NUM_REQ,
  parameter int WORD_SIZE  = response_pkg::WORD_SIZE,
  parameter int FIFO_DEPTH = response_pkg::FIFO_DEPTH,
  parameter int CNT_W      = response_pkg::CNT_W,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_write_enable,
  output logic [WORD_SIZE-1:0]         fifo_data_in,
  input  logic                         fifo_read_enable,
  output logic [CNT_W-1:0]             occupancy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         underflow_err
);

  logic [ID_W-1:0]      last_ptr;
  logic                 has_space;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 accept;
  logic                 pop_ok;
  logic [WORD_SIZE-1:0] sel_word;

  // Compared against the registered count only, so a pop frees a slot one
  // cycle later; this keeps req_ready off the consumer's timing path.
  assign has_space = (occupancy < CNT_W'(FIFO_DEPTH));

  rr_arbiter #(
    .NREQ  (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_valid (req_valid),
    .last_ptr  (last_ptr),
    .has_space (has_space),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = reset ? '0 : grant;
  assign accept    = |(req_valid & req_ready);
  // A pop against an empty count is not a real entry leaving.
  assign pop_ok    = fifo_read_enable && (occupancy != '0);

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_word = req_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_write_enable <= 1'b0;
      fifo_data_in      <= '0;
      occupancy         <= '0;
      grant_id          <= '0;
      underflow_err     <= 1'b0;
      // Points at the last slot so the first search starts at source 0.
      last_ptr          <= ID_W'(NUM_REQ - 1);
    end else begin
      fifo_write_enable <= accept;
      if (accept) begin
        fifo_data_in <= sel_word;
        grant_id     <= grant_idx;
        last_ptr     <= grant_idx;
      end
      case ({accept, pop_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (fifo_read_enable && (occupancy == '0)) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_response_fifo_arbiter.sv
module tb_response_fifo_arbiter;

  localparam int N     = 4;
  localparam int WS    = 45;
  localparam int DEPTH = 21;
  localparam int CW    = 5;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*WS-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_write_enable;
  logic [WS-1:0]   fifo_data_in;
  logic            fifo_read_enable;
  logic [CW-1:0]   occupancy;
  logic [1:0]      grant_id;
  logic            underflow_err;

  response_fifo_arbiter #(
    .NUM_REQ    (N),
    .WORD_SIZE  (WS),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .fifo_write_enable (fifo_write_enable),
    .fifo_data_in      (fifo_data_in),
    .fifo_read_enable  (fifo_read_enable),
    .occupancy         (occupancy),
    .grant_id          (grant_id),
    .underflow_err     (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain integers following the written rules.
  int          m_occ  = 0;
  int          m_last = N - 1;
  logic        m_wen  = 1'b0;
  logic [WS-1:0] m_data = '0;
  int          m_gid  = 0;
  logic        m_uf   = 1'b0;
  logic [WS-1:0] src [N];

  function automatic logic [WS-1:0] rand_word();
    return WS'({$urandom(), $urandom()});
  endfunction

  // Round-robin choice: first valid source after the last winner; none if full.
  function automatic int model_pick(input logic [N-1:0] v);
    if (m_occ >= DEPTH) return -1;
    for (int off = 1; off <= N; off++) begin
      if (v[(m_last + off) % N]) return (m_last + off) % N;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check the grant, then check the
  // registered outputs just after the rising edge.
  task automatic step(input logic [N-1:0] v, input logic p, input logic r);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    req_valid        = v;
    fifo_read_enable = p;
    reset            = r;
    for (int i = 0; i < N; i++) req_data[i*WS +: WS] = src[i];
    #1;
    g       = r ? -1 : model_pick(v);
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_occ = 0; m_last = N - 1; m_wen = 1'b0; m_data = '0; m_gid = 0; m_uf = 1'b0;
    end else begin
      m_wen = (g >= 0);
      if (p && m_occ == 0) m_uf = 1'b1;
      if (p && m_occ > 0) m_occ = m_occ - 1;
      if (g >= 0) begin
        m_data = src[g];
        m_gid  = g;
        m_last = g;
        m_occ  = m_occ + 1;
        src[g] = rand_word();
      end
    end
    #1;
    check("fifo_write_enable", 64'(fifo_write_enable), 64'(m_wen));
    check("fifo_data_in", 64'(fifo_data_in), 64'(m_data));
    check("occupancy", 64'(occupancy), 64'(m_occ));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    check("underflow_err", 64'(underflow_err), 64'(m_uf));
  endtask

  initial begin
    reset            = 1'b1;
    req_valid        = '0;
    req_data         = '0;
    fifo_read_enable = 1'b0;
    for (int i = 0; i < N; i++) src[i] = rand_word();

    // Reset state
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    check("reset_occ", 64'(occupancy), 64'd0);
    check("reset_wen", 64'(fifo_write_enable), 64'd0);

    // Underflow from reset, then normal counting from 0
    step('0, 1'b1, 1'b0);
    check("uf_flag", 64'(underflow_err), 64'd1);
    check("uf_occ", 64'(occupancy), 64'd0);
    for (int k = 0; k < 3; k++) step(4'b0001, 1'b0, 1'b0);
    check("uf_count", 64'(occupancy), 64'd3);
    check("uf_sticky", 64'(underflow_err), 64'd1);

    // Fairness: all valid -> grants 0,1,2,3,0
    step('0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0, 1'b0);
      check("fair_gid", 64'(grant_id), 64'(k % N));
      check("fair_wen", 64'(fifo_write_enable), 64'd1);
    end

    // Reset mid-burst at occupancy 7
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    check("burst_occ7", 64'(occupancy), 64'd7);
    step(4'b1111, 1'b0, 1'b1);
    check("midrst_wen", 64'(fifo_write_enable), 64'd0);
    check("midrst_occ", 64'(occupancy), 64'd0);
    step(4'b1111, 1'b0, 1'b0);
    check("midrst_first_gid", 64'(grant_id), 64'd0);

    // Fill with source 2 only
    step('0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH + 3; k++) step(4'b0100, 1'b0, 1'b0);
    check("fill_occ", 64'(occupancy), 64'(DEPTH));
    check("fill_ready", 64'(req_ready), 64'd0);
    check("fill_wen", 64'(fifo_write_enable), 64'd0);

    // Full recovery: one pop frees one slot a cycle later
    step(4'b0100, 1'b1, 1'b0);
    check("recover_occ", 64'(occupancy), 64'(DEPTH - 1));
    step(4'b0100, 1'b0, 1'b0);
    check("recover_occ_full", 64'(occupancy), 64'(DEPTH));
    check("recover_wen", 64'(fifo_write_enable), 64'd1);

    // Simultaneous accept and pop at occupancy 10
    for (int k = 0; k < DEPTH - 10; k++) step('0, 1'b1, 1'b0);
    check("sim_pre_occ", 64'(occupancy), 64'd10);
    step(4'b0100, 1'b1, 1'b0);
    check("sim_occ", 64'(occupancy), 64'd10);
    check("sim_wen", 64'(fifo_write_enable), 64'd1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(N'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/response_fifo_arbiter.md
# response_fifo_arbiter

Shares the single processor response FIFO among `NUM_REQ` response sources, such as execution units or memory ports. Each cycle it picks at most one valid source, in round-robin order, and forwards that source's word to the FIFO write port through one register stage. It keeps its own occupancy counter, so it never writes into a full FIFO and never depends on the FIFO's registered full/empty flags.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of response sources.
- `WORD_SIZE`, default 45: response word width.
- `FIFO_DEPTH`, default 21: usable entries in the downstream FIFO.
- `CNT_W`, default 5: occupancy counter width; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-source word available.
- `req_data`  in  NUM_REQ*WORD_SIZE  source i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- `req_ready`  out  NUM_REQ  one-hot or zero; grant for this cycle.
- `fifo_write_enable`  out  1  registered write strobe to the FIFO.
- `fifo_data_in`  out  WORD_SIZE  registered write data.
- `fifo_read_enable`  in  1  consumer pop, the same signal that drives the FIFO.
- `occupancy`  out  CNT_W  reserved entries (accepted minus popped).
- `grant_id`  out  log2(NUM_REQ)  index of the last accepted source.
- `underflow_err`  out  1  sticky; set by a pop when occupancy is 0.

## Operation
- Transfer rule: a word transfers when `req_valid[i]` and `req_ready[i]` are both high. The source holds its data stable while valid and not ready.
- `has_space`: high when `occupancy` < FIFO_DEPTH, evaluated on the registered count.
- Grant selection:
  - `req_ready` is combinational from `req_valid`, `last_ptr` and `has_space`, and is forced to 0 while `reset` is high.
  - The search starts at `last_ptr`+1 and wraps modulo NUM_REQ. The first valid source found is granted.
  - If no source is valid, or `has_space` is 0, no grant is made.
- On an accepted transfer:
  - `last_ptr` and `grant_id` take the granted index.
  - `fifo_data_in` takes that source's word.
  - `fifo_write_enable` is 1 on the next cycle, and 0 in every cycle with no accept.
- Occupancy update:
  - accept only: +1
  - valid pop only: −1
  - both in the same cycle: unchanged
  - neither: unchanged
- A pop with `occupancy` = 0 is ignored for counting and sets `underflow_err`. The flag clears only on reset.
- The counter never exceeds FIFO_DEPTH; this follows by construction because `has_space` gates every accept.

## Timing
- Reset values:
  - `fifo_write_enable` = 0
  - `fifo_data_in` = 0
  - `occupancy` = 0
  - `grant_id` = 0
  - `underflow_err` = 0
  - `last_ptr` = NUM_REQ−1, so source 0 wins first
  - `req_ready` = 0
- Latency: accept in cycle N gives `fifo_write_enable` = 1 and `fifo_data_in` = the word in cycle N+1.
- Throughput: one accept per cycle.
- Full boundary:
  - At `occupancy` = FIFO_DEPTH, a pop in cycle N gives `has_space` = 1 in cycle N+1.
  - There is no same-cycle bypass; one bubble is accepted.
- Reset mid-operation: a registered write pending in the cycle `reset` is high is dropped (`fifo_write_enable` = 0 next cycle). The FIFO is reset in the same cycle.
- Pop against a write:
  - A pop counts against `occupancy` at the edge it is sampled.
  - Reservation happens at accept, so the FIFO never sees a write beyond FIFO_DEPTH held entries.

## Structure
- Shared package `response_pkg`: `WORD_SIZE`, `FIFO_DEPTH`, `NUM_REQ`, `CNT_W`, and the grant-index width constant, shared with the FIFO and the response sources.
- One sub-module `rr_arbiter`: combinational rotate-priority search over `req_valid` from `last_ptr`, qualified by `has_space`. Outputs the one-hot grant and the encoded index.
- The top holds `last_ptr`, the occupancy counter, the write register and `underflow_err`.

## Test plan
- Fairness: after reset, hold all 4 `req_valid` high with no pops → grants 0,1,2,3,0 on consecutive cycles. `fifo_write_enable` is high from cycle 2 onward, with `fifo_data_in` matching each source a cycle later.
- Fill: hold only source 2 valid, no pops → exactly 21 accepts, `occupancy` = 21, then `req_ready` = 0 indefinitely.
- Full recovery: at `occupancy` = 21, pop once → next cycle `occupancy` = 20 and `req_ready[2]` = 1. Accept → `occupancy` = 21.
- Simultaneous events: at `occupancy` = 10, accept and pop in the same cycle → `occupancy` stays 10 and `fifo_write_enable` = 1 next cycle.
- Underflow: from reset, pulse `fifo_read_enable` → `underflow_err` = 1, `occupancy` = 0. Subsequent accepts count normally from 0.
- Reset mid-burst: assert `reset` during the all-valid stream at `occupancy` = 7 → next cycle all outputs are at reset values, and the first grant after release goes to source 0.
